ascon_perm_arbiter: RTL and testbench

ASCON_PERM_ARBITER -- requirements
Module: ascon_perm_arbiter

---
 rtl/ascon_perm_arbiter.sv | 146 ++++++++++++++
 tb/tb_ascon_perm_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_arbiter.sv
// ascon_perm_arbiter
//   Shares one masked Ascon permutation core between two clients.
//   A client is granted on request. Simultaneous requests alternate
//   round-robin. The winner's round count is latched and the core is
//   started. Ownership is held until the client drops its request.
//   A watchdog abandons a run whose core never reports ready.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_0/1, rounds_0/1       client requests and requested round counts
//   grant_0/1, done_0/1       core ownership, one-cycle completion pulse
//   perm_start, perm_rounds   start and round count to the core
//   perm_sel                  core state-input mux select (0 = client 0)
//   perm_ready                core completion
//   busy                      arbiter not idle
//   timeout_err               sticky watchdog flag
//
// state   | meaning
// IDLE    | no owner; grant on the next sampled request
// RUN     | core started for the owner; waiting for perm_ready or watchdog
// RELEASE | run finished; owner keeps the grant until it drops req
module ascon_perm_arbiter #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_0,
   input  logic       req_1,
   input  logic [4:0] rounds_0,
   input  logic [4:0] rounds_1,
   output logic       grant_0,
   output logic       grant_1,
   output logic       done_0,
   output logic       done_1,
   output logic       perm_start,
   output logic [4:0] perm_rounds,
   output logic       perm_sel,
   input  logic       perm_ready,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_RELEASE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic       grant_0_d, grant_1_d, done_0_d, done_1_d;
   logic       perm_start_d, perm_sel_d, busy_d, timeout_err_d;
   logic [4:0] perm_rounds_d;
   logic       pick;
   logic       owner_req;

   // A lone request always wins; a tie goes to the client not served last.
   assign pick      = (req_0 & req_1) ? ~last_q : req_1;
   assign owner_req = perm_sel ? req_1 : req_0;

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      grant_0_d     = grant_0;
      grant_1_d     = grant_1;
      done_0_d      = 1'b0;
      done_1_d      = 1'b0;
      perm_start_d  = perm_start;
      perm_rounds_d = perm_rounds;
      perm_sel_d    = perm_sel;
      timeout_err_d = timeout_err;
      case (state_q)
         ST_IDLE: begin
            if (req_0 | req_1) begin
               grant_0_d     = ~pick;
               grant_1_d     = pick;
               perm_start_d  = 1'b1;
               perm_rounds_d = pick ? rounds_1 : rounds_0;
               perm_sel_d    = pick;
               last_d        = pick;
               cnt_d         = 8'd0;
               state_d       = ST_RUN;
            end
         end
         ST_RUN: begin
            // Ready wins over a watchdog expiry in the same cycle.
            if (perm_ready) begin
               perm_start_d = 1'b0;
               done_0_d     = ~perm_sel;
               done_1_d     = perm_sel;
               state_d      = ST_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               perm_start_d  = 1'b0;
               timeout_err_d = 1'b1;
               state_d       = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RELEASE: begin
            if (!owner_req) begin
               grant_0_d = 1'b0;
               grant_1_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;  // "client 1 served last" so a first tie goes to client 0
         cnt_q       <= 8'd0;
         grant_0     <= 1'b0;
         grant_1     <= 1'b0;
         done_0      <= 1'b0;
         done_1      <= 1'b0;
         perm_start  <= 1'b0;
         perm_rounds <= 5'd0;
         perm_sel    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         grant_0     <= grant_0_d;
         grant_1     <= grant_1_d;
         done_0      <= done_0_d;
         done_1      <= done_1_d;
         perm_start  <= perm_start_d;
         perm_rounds <= perm_rounds_d;
         perm_sel    <= perm_sel_d;
         busy        <= busy_d;
         timeout_err <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// tb_ascon_perm_arbiter
//   Directed bench for ascon_perm_arbiter. A transaction-level model
//   (owner, run length, last-served client) predicts every output each
//   cycle. Literal checks at key points pin the model.
module tb_ascon_perm_arbiter;
   localparam int TO = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_0 = 1'b0, req_1 = 1'b0, perm_ready = 1'b0;
   logic [4:0] rounds_0 = 5'd0, rounds_1 = 5'd0;
   logic       grant_0, grant_1, done_0, done_1, perm_start, perm_sel, busy, timeout_err;
   logic [4:0] perm_rounds;

   ascon_perm_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1),
      .rounds_0(rounds_0), .rounds_1(rounds_1),
      .grant_0(grant_0), .grant_1(grant_1), .done_0(done_0), .done_1(done_1),
      .perm_start(perm_start), .perm_rounds(perm_rounds), .perm_sel(perm_sel),
      .perm_ready(perm_ready), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;

   // Model: owner -1 means free; run_len counts RUN cycles so far.
   int         m_owner = -1, m_last = 1, m_run_len = 0, m_w;
   bit         m_running = 0, m_start = 0, m_sel = 0, m_done0 = 0, m_done1 = 0, m_terr = 0;
   logic [4:0] m_rounds = 5'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_last = 1; m_run_len = 0; m_running = 0;
         m_start = 0; m_sel = 0; m_done0 = 0; m_done1 = 0; m_terr = 0; m_rounds = 5'd0;
      end else begin
         m_done0 = 0; m_done1 = 0;
         if (m_owner < 0) begin
            if (req_0 || req_1) begin
               if (req_0 && req_1) m_w = (m_last == 0) ? 1 : 0;
               else                m_w = req_1 ? 1 : 0;
               m_owner = m_w; m_last = m_w; m_running = 1; m_run_len = 0;
               m_rounds = (m_w == 1) ? rounds_1 : rounds_0;
               m_sel = (m_w == 1); m_start = 1;
            end
         end else if (m_running) begin
            m_run_len++;
            if (perm_ready) begin
               m_running = 0; m_start = 0;
               if (m_owner == 0) m_done0 = 1; else m_done1 = 1;
            end else if (m_run_len == TO) begin
               m_running = 0; m_start = 0; m_terr = 1;
            end
         end else begin
            if ((m_owner == 0 && !req_0) || (m_owner == 1 && !req_1)) m_owner = -1;
         end
      end
   end

   logic [13:0] exp_v, act_v;
   always @(negedge clk) begin
      if (chk_en) begin
         exp_v = {m_owner == 0, m_owner == 1, m_done0, m_done1, m_start, m_rounds,
                  m_sel, m_owner >= 0, m_terr};
         act_v = {grant_0, grant_1, done_0, done_1, perm_start, perm_rounds,
                  perm_sel, busy, timeout_err};
         n_chk++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: got %b expected %b (g0 g1 d0 d1 st rnd sel busy terr)",
                     $time, act_v, exp_v);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_start(input string nm);
      for (int i = 0; i < 20 && perm_start !== 1'b1; i++) @(negedge clk);
      n_chk++;
      if (perm_start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: got perm_start=%b expected 1 within 20 cycles", nm, perm_start);
      end
   endtask

   task automatic pulse_ready(input int dly);
      repeat (dly) @(negedge clk);
      perm_ready = 1'b1;
      @(negedge clk);
      perm_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int ord[3] = '{0, 1, 0};
   int cyc;

   initial begin
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_grant_0", grant_0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perm_rounds", perm_rounds, 0);
      rst = 1'b0;

      // single client, ready 12 cycles after start
      req_0 = 1'b1; rounds_0 = 5'd12;
      wait_start("t1_start");
      chk("t1_grant_0", grant_0, 1);
      chk("t1_perm_rounds", perm_rounds, 12);
      chk("t1_perm_sel", perm_sel, 0);
      pulse_ready(12);
      chk("t1_done_0", done_0, 1);
      req_0 = 1'b0;
      @(negedge clk);
      chk("t1_done_0_cleared", done_0, 0);
      chk("t1_grant_0_dropped", grant_0, 0);

      // both held: round-robin 0,1,0
      do_reset();
      rounds_0 = 5'd12; rounds_1 = 5'd6; req_0 = 1'b1; req_1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_start("rr_start");
         chk("rr_grant_0", grant_0, (ord[k] == 0) ? 1 : 0);
         chk("rr_grant_1", grant_1, (ord[k] == 1) ? 1 : 0);
         chk("rr_perm_rounds", perm_rounds, (ord[k] == 1) ? 6 : 12);
         pulse_ready(3);
         if (ord[k] == 0) req_0 = 1'b0; else req_1 = 1'b0;
         @(negedge clk);
         if (k < 2) begin
            if (ord[k] == 0) req_0 = 1'b1; else req_1 = 1'b1;
         end
      end
      req_1 = 1'b0;
      @(negedge clk);
      chk("rr_idle_busy", busy, 0);

      // ready on the very cycle the watchdog expires counts as completion
      req_0 = 1'b1;
      wait_start("edge_start");
      repeat (TO - 1) @(negedge clk);
      perm_ready = 1'b1;
      @(negedge clk);
      perm_ready = 1'b0;
      chk("edge_done_0", done_0, 1);
      chk("edge_timeout_err", timeout_err, 0);
      req_0 = 1'b0;
      @(negedge clk);

      // watchdog: ready never comes
      req_0 = 1'b1;
      wait_start("to_start");
      cyc = 0;
      while (perm_start === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk("to_start_cycles", cyc, TO);
      chk("to_timeout_err", timeout_err, 1);
      chk("to_done_0", done_0, 0);
      chk("to_grant_held", grant_0, 1);
      req_0 = 1'b0;
      @(negedge clk);
      chk("to_busy_after_drop", busy, 0);
      chk("to_err_sticky", timeout_err, 1);

      // rounds change mid-run, then spurious ready while idle
      req_1 = 1'b1; rounds_1 = 5'd12;
      wait_start("rnd_start");
      chk("rnd_grant_1", grant_1, 1);
      rounds_1 = 5'd6;
      pulse_ready(4);
      chk("rnd_perm_rounds", perm_rounds, 12);
      chk("rnd_done_1", done_1, 1);
      req_1 = 1'b0;
      @(negedge clk);
      perm_ready = 1'b1;
      repeat (2) @(negedge clk);
      perm_ready = 1'b0;
      chk("spur_busy", busy, 0);
      chk("spur_done_1", done_1, 0);
      chk("spur_perm_rounds", perm_rounds, 12);

      // reset 5 cycles into RUN, then a tie goes to client 0
      req_0 = 1'b1; rounds_0 = 5'd9;
      wait_start("rst_run_start");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstrun_grant_0", grant_0, 0);
      chk("rstrun_perm_start", perm_start, 0);
      chk("rstrun_perm_rounds", perm_rounds, 0);
      chk("rstrun_busy", busy, 0);
      chk("rstrun_timeout_err", timeout_err, 0);
      chk("rstrun_done_0", done_0, 0);
      rst = 1'b0; req_1 = 1'b1;
      @(negedge clk);
      chk("rstrun_tie_grant_0", grant_0, 1);
      chk("rstrun_tie_grant_1", grant_1, 0);
      req_0 = 1'b0; req_1 = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
